uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver that deserialises an asynchronous serial line into a parallel word of configurable width. It adds input synchronisation, start-bit glitch rejection, one or two stop bits, framing-error reporting and optional parity checking. It sits at the serial ingress of the FPGA, between the board RX pin and the command/FIFO logic, and its output pulses one `valid` per received frame.

## Interface
- `CLK_FREQUENCY`, 66_000_000, fabric clock frequency in Hz
- `BAUD_RATE`, 921_600, serial bit rate in bit/s
- `DATA_BITS`, 8, data bits per frame, legal range 5..9
- `STOP_BITS`, 1, stop bits per frame, 1 or 2
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- `clk`  input  1  clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `rx`  input  1  raw serial line, idle high, LSB first
- `data`  output  DATA_BITS  last received word, held until next `valid`
- `valid`  output  1  one-cycle pulse, frame complete
- `frame_err`  output  1  qualified by `valid`: a stop-bit sample was 0
- `parity_err`  output  1  qualified by `valid`: parity mismatch, constant 0 when parity is compiled out
- `busy`  output  1  high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All logic below uses the synchronised value `rx_s`.
- `TICKS = CLK_FREQUENCY/BAUD_RATE` (integer division). `HALF = TICKS/2`.
- The tick counter is `$clog2(TICKS)` bits wide. It clears on every state entry and on every sample point.
- Elaboration fails if `TICKS < 4`, `DATA_BITS` is outside 5..9, or `STOP_BITS` is outside 1..2.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE: when `rx_s` = 0, go to START.
- START: at tick `HALF-1`, sample `rx_s`.
  - Sample = 1: glitch. Return to IDLE with no output and no flags.
  - Sample = 0: go to DATA.
- DATA: sample `rx_s` every `TICKS` cycles (mid-bit) into a shift register, LSB first. The bit index is 0..DATA_BITS-1. After the last bit, go to PARITY if compiled in, otherwise to STOP.
- PARITY: one mid-bit sample. Compute XOR of the data bits, the parity bit, and `PARITY_ODD`. A result of 1 sets the internal parity error. Then go to STOP.
- STOP: `STOP_BITS` mid-bit samples. Any sample of 0 sets the internal framing error.
- After the final stop sample, the FSM goes directly to IDLE. It does not wait out the back half of the stop bit, so the next start edge can be caught.
- On the cycle after the final stop sample:
  - `data` is loaded.
  - `valid` = 1.
  - `frame_err` and `parity_err` are driven from the internal flags.
  - Internal flags clear on START entry.
- `data` is updated even on error frames.
- `frame_err` and `parity_err` are 0 whenever `valid` = 0.
- A break condition (line held low) produces a frame with `data` = 0 and `frame_err` = 1. The FSM then waits in IDLE for `rx_s` = 1 before it may arm again. It must not re-trigger on a held-low line.

## Timing
- Reset values: `data` = 0, `valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0, state = IDLE, counters = 0. Reset takes effect immediately, including mid-frame. The first frame after reset release needs a fresh falling edge.
- Synchroniser latency is 2 cycles. Cycle 0 is the first cycle with `rx_s` = 0 in IDLE.
- Start sample: cycle HALF.
- Data bit i: cycle HALF + (i+1)·TICKS.
- Parity (if enabled): cycle HALF + (DATA_BITS+1)·TICKS.
- Stop k (k = 0..STOP_BITS-1): cycle HALF + (DATA_BITS+P+1+k)·TICKS, where P = 1 if parity is enabled, otherwise 0.
- `valid` is high for exactly one cycle, on the cycle after the last stop sample.
- `busy` rises on cycle 1 and falls together with `valid`.
- Back-to-back frames are received with no lost frame. The minimum gap is zero idle bits.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is built.
  - One parity bit is expected between the data bits and the stop bits.
  - `parity_err` reports mismatches against `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes straight to STOP.
  - `parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Test plan
All scenarios use CLK_FREQUENCY = 16_000_000 and BAUD_RATE = 1_000_000 (TICKS = 16), with DATA_BITS = 8 and STOP_BITS = 1 unless stated otherwise.
- Send 0xA5 at 16 cycles/bit -> one `valid` pulse with `data` = 0xA5, `frame_err` = 0, `parity_err` = 0, 155 cycles after the raw `rx` falling edge (2 sync + HALF + 9·TICKS + 1).
- Send 0x3C and 0xC3 back-to-back with no idle gap -> two `valid` pulses, `data` = 0x3C then 0xC3.
- Pulse `rx` low for 4 cycles -> no `valid`, `busy` returns to 0 by cycle 10, and a following 0x55 frame is received correctly.
- Send 0x81 with the stop bit driven 0, then hold `rx` low for 40 cycles -> exactly one `valid` with `frame_err` = 1, and no second frame until `rx` returns high.
- With `UART_RX_PARITY_EN` and `PARITY_ODD` = 0:
  - 0x07 with parity bit 1 -> `parity_err` = 0.
  - Same frame with parity bit 0 -> `parity_err` = 1, `data` = 0x07.
- With DATA_BITS = 5 and STOP_BITS = 2, send 0x1B, then assert `rst_n` low mid-frame -> the first frame gives `data` = 0x1B; the reset returns all outputs to reset values immediately with no `valid`.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg : parametrised UART receiver (sync, glitch reject, 1/2 stop,
//               framing error, optional parity via UART_RX_PARITY_EN)
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_cfg #(
  parameter int CLK_FREQUENCY = 66_000_000,
  parameter int BAUD_RATE     = 921_600,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TICKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF  = TICKS / 2;
  localparam int CNT_W = $clog2(TICKS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TICKS - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (TICKS < 4) begin : g_chk_ticks
      $error("uart_rx_cfg: CLK_FREQUENCY/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
      $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  logic                 rx_m, rx_s;
  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr;
  logic                 armed;
  logic                 sample, last_stop, start_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_m, rx_s} <= 2'b11;
    else        {rx_m, rx_s} <= {rx, rx_m};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    sample      = 1'b0;
    last_stop   = 1'b0;
    start_entry = 1'b0;
    case (state)
      IDLE: if (!rx_s && armed) begin
        state_next  = START;
        start_entry = 1'b1;
      end
      START: if (cnt == CNT_HALF) begin
        sample     = 1'b1;
        state_next = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == CNT_FULL) begin
        sample = 1'b1;
        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == CNT_FULL) begin
        sample     = 1'b1;
        state_next = STOP;
      end
`endif
      STOP: if (cnt == CNT_FULL) begin
        sample = 1'b1;
        if (stop_idx == STOP_LAST) begin
          last_stop  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A frame ending on a low line (break) disarms until the line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      ferr     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (state == IDLE || state_next != state || sample) cnt <= '0;
      else                                                 cnt <= cnt + CNT_W'(1);

      if (state != DATA) bit_idx <= '0;
      else if (sample)   bit_idx <= bit_idx + 4'd1;

      if (state != STOP) stop_idx <= 1'b0;
      else if (sample)   stop_idx <= ~stop_idx;

      if (state == DATA && sample) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

      if (start_entry)                         ferr <= 1'b0;
      else if (state == STOP && sample && !rx_s) ferr <= 1'b1;

      if (last_stop && !rx_s)          armed <= 1'b0;
      else if (state == IDLE && rx_s)  armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= last_stop;
      frame_err <= last_stop & (ferr | ~rx_s);
      if (last_stop) data <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_entry)                    perr <= 1'b0;
      else if (state == PARITY && sample) perr <= (^shreg) ^ rx_s ^ PAR_ODD;
      parity_err <= last_stop & perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg : scoreboard bench for uart_rx_cfg (8N1 and 5-bit/2-stop)
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n, rx0, rx1;
  logic [7:0] data0;
  logic [4:0] data1;
  logic       valid0, fe0, pe0, busy0;
  logic       valid1, fe1, pe1, busy1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLK_FREQUENCY(16_000_000), .BAUD_RATE(1_000_000),
                .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .rx(rx0), .data(data0), .valid(valid0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0));

  uart_rx_cfg #(.CLK_FREQUENCY(16_000_000), .BAUD_RATE(1_000_000),
                .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .rx(rx1), .data(data1), .valid(valid1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input logic [8:0] d, input logic fe,
                      input logic pe, input int at);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.at = at;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  task automatic drive(input int which, input logic b, input int ncyc);
    if (which == 0) rx0 = b;
    else            rx1 = b;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic frame(input int which, input logic [8:0] d, input int nbits,
                       input int nstop, input logic stop_val, input logic par_flip);
    drive(which, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(which, d[i], 16);
`ifdef UART_RX_PARITY_EN
    begin : b_par
      logic p;
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ d[i];
      drive(which, p ^ par_flip, 16);
    end
`endif
    for (int k = 0; k < nstop; k++) drive(which, stop_val, 16);
  endtask

  always @(negedge clk) begin
    if (valid0) begin
      if (q0.size() == 0) begin
        check("unexpected_valid0", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("data0", int'(data0), int'(e.d[7:0]));
        check("frame_err0", int'(fe0), int'(e.fe));
        check("parity_err0", int'(pe0), int'(e.pe));
        if (e.at >= 0) check("latency0", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin
    if (valid1) begin
      if (q1.size() == 0) begin
        check("unexpected_valid1", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("data1", int'(data1), int'(e.d[4:0]));
        check("frame_err1", int'(fe1), int'(e.fe));
        check("parity_err1", int'(pe1), int'(e.pe));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rx0 = 1'b1; rx1 = 1'b1; rst0_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data0", int'(data0), 0);
    check("rst_valid0", int'(valid0), 0);
    check("rst_fe0", int'(fe0), 0);
    check("rst_pe0", int'(pe0), 0);
    check("rst_busy0", int'(busy0), 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (5) @(negedge clk);

    // single frame with latency from the raw falling edge
    push(0, 9'h0A5, 1'b0, 1'b0, cyc + 155 + 16 * P);
    frame(0, 9'h0A5, 8, 1, 1'b1, 1'b0);
    drive(0, 1'b1, 20);

    // back-to-back, zero idle gap
    push(0, 9'h03C, 1'b0, 1'b0, -1);
    push(0, 9'h0C3, 1'b0, 1'b0, -1);
    frame(0, 9'h03C, 8, 1, 1'b1, 1'b0);
    frame(0, 9'h0C3, 8, 1, 1'b1, 1'b0);
    drive(0, 1'b1, 20);

    // 4-cycle glitch is rejected
    k = cyc;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2);
    check("glitch_busy_c4", int'(busy0), 1);
    check("glitch_cyc", cyc - k, 6);
    repeat (6) @(negedge clk);
    check("glitch_busy_c10", int'(busy0), 0);
    push(0, 9'h055, 1'b0, 1'b0, -1);
    frame(0, 9'h055, 8, 1, 1'b1, 1'b0);
    drive(0, 1'b1, 20);

    // stop bit low then line held low: one frame only
    push(0, 9'h081, 1'b1, 1'b0, -1);
    frame(0, 9'h081, 8, 1, 1'b0, 1'b0);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 20);
    push(0, 9'h05A, 1'b0, 1'b0, -1);
    frame(0, 9'h05A, 8, 1, 1'b1, 1'b0);
    drive(0, 1'b1, 20);

    // full break
    push(0, 9'h000, 1'b1, 1'b0, -1);
    drive(0, 1'b0, 16 * 14);
    drive(0, 1'b1, 20);

`ifdef UART_RX_PARITY_EN
    push(0, 9'h007, 1'b0, 1'b0, -1);
    frame(0, 9'h007, 8, 1, 1'b1, 1'b0);
    drive(0, 1'b1, 20);
    push(0, 9'h007, 1'b0, 1'b1, -1);
    frame(0, 9'h007, 8, 1, 1'b1, 1'b1);
    drive(0, 1'b1, 20);
`endif

    // 5 data bits, 2 stop bits, then reset mid-frame
    push(1, 9'h01B, 1'b0, 1'b0, -1);
    frame(1, 9'h01B, 5, 2, 1'b1, 1'b0);
    drive(1, 1'b1, 10);
    drive(1, 1'b0, 16);
    drive(1, 1'b1, 16);
    drive(1, 1'b0, 8);
    rst1_n = 1'b0;
    #1;
    check("midrst_data1", int'(data1), 0);
    check("midrst_valid1", int'(valid1), 0);
    check("midrst_fe1", int'(fe1), 0);
    check("midrst_pe1", int'(pe1), 0);
    check("midrst_busy1", int'(busy1), 0);
    @(negedge clk);
    drive(1, 1'b1, 30);
    rst1_n = 1'b1;
    repeat (5) @(negedge clk);
    push(1, 9'h015, 1'b0, 1'b0, -1);
    frame(1, 9'h015, 5, 2, 1'b1, 1'b0);
    drive(1, 1'b1, 50);

    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
